// File: rtl/bypass_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bypass_hazard_unit_pkg
// Purpose  : Shared select codes and width helpers for the bypass/hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
package bypass_hazard_unit_pkg;

    localparam int FW_SEL_RF = 0;

    // The long-latency write-back path sits just past the last pipeline stage.
    function automatic int fw_sel_lg(input int num_fwd);
        return num_fwd + 1;
    endfunction

    function automatic int sel_width(input int num_fwd);
        return $clog2(num_fwd + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bypass_src_match.sv
`default_nettype none
// ============================================================================
// Module   : bypass_src_match
// Purpose  : Priority matcher for one decode source: picks bypass select, flags stall.
// Revision : 1.0 - initial release
// ============================================================================
module bypass_src_match
    import bypass_hazard_unit_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int AW      = 5,
    parameter int SEL_W   = 2
) (
    input  logic [AW-1:0]         addr,
    input  logic                  used,
    input  logic [NUM_FWD*AW-1:0] st_dest,
    input  logic [NUM_FWD-1:0]    st_we,
    input  logic [NUM_FWD-1:0]    st_rdy,
    input  logic                  lg_wb,
    input  logic [AW-1:0]         lg_wb_dest,
    input  logic                  busy,
    output logic [SEL_W-1:0]      sel,
    output logic                  stall
);

    logic w_found;

    always_comb begin
        sel     = SEL_W'(FW_SEL_RF);
        stall   = 1'b0;
        w_found = 1'b0;
        // Youngest stage (index 0) is scanned first and locks out older ones.
        for (int k = 0; k < NUM_FWD; k++) begin
            if (!w_found && st_we[k] && (st_dest[k*AW +: AW] == addr)) begin
                w_found = 1'b1;
                sel     = SEL_W'(k + 1);
                stall   = ~st_rdy[k];
            end
        end
        if (!w_found) begin
            if (lg_wb && (lg_wb_dest == addr)) begin
                sel = SEL_W'(fw_sel_lg(NUM_FWD));
            end else if (busy) begin
                stall = 1'b1;
            end
        end
        if (!used) begin
            sel   = SEL_W'(FW_SEL_RF);
            stall = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bypass_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : bypass_hazard_unit
// Purpose  : Operand bypass select, load-use/scoreboard stall and busy-bit
//            scoreboard. Optional stall counter under BYPASS_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bypass_hazard_unit
    import bypass_hazard_unit_pkg::*;
#(
    parameter int  NUM_SRC = 2,
    parameter int  NUM_FWD = 2,
    parameter int  AW      = 5,
    localparam int SEL_W   = sel_width(NUM_FWD),
    localparam int REG_NUM = 1 << AW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ds_valid,
    input  logic [NUM_SRC*AW-1:0]    ds_src_addr,
    input  logic [NUM_SRC-1:0]       ds_src_used,
    input  logic [NUM_FWD*AW-1:0]    st_dest,
    input  logic [NUM_FWD-1:0]       st_we,
    input  logic [NUM_FWD-1:0]       st_rdy,
    input  logic                     lg_issue,
    input  logic [AW-1:0]            lg_issue_dest,
    input  logic                     lg_wb,
    input  logic [AW-1:0]            lg_wb_dest,
    input  logic                     flush,
    output logic [NUM_SRC*SEL_W-1:0] fw_sel,
    output logic                     ds_stall,
    output logic [REG_NUM-1:0]       sb_busy
`ifdef BYPASS_PERF_CNT_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    logic [REG_NUM-1:0] r_busy;
    logic [REG_NUM-1:0] w_busy_nxt;
    logic [NUM_SRC-1:0] w_used;
    logic [NUM_SRC-1:0] w_src_busy;
    logic [NUM_SRC-1:0] w_src_stall;
    logic               w_waw;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            assign w_used[i]     = ds_valid & ds_src_used[i] & (|ds_src_addr[i*AW +: AW]);
            assign w_src_busy[i] = r_busy[ds_src_addr[i*AW +: AW]];

            bypass_src_match #(
                .NUM_FWD (NUM_FWD),
                .AW      (AW),
                .SEL_W   (SEL_W)
            ) u_match (
                .addr       (ds_src_addr[i*AW +: AW]),
                .used       (w_used[i]),
                .st_dest    (st_dest),
                .st_we      (st_we),
                .st_rdy     (st_rdy),
                .lg_wb      (lg_wb),
                .lg_wb_dest (lg_wb_dest),
                .busy       (w_src_busy[i]),
                .sel        (fw_sel[i*SEL_W +: SEL_W]),
                .stall      (w_src_stall[i])
            );
        end
    endgenerate

    // A second long op to a still-busy register would reorder write-backs.
    assign w_waw = ds_valid & lg_issue & r_busy[lg_issue_dest]
                 & ~(lg_wb & (lg_wb_dest == lg_issue_dest));

    assign ds_stall = (|w_src_stall) | w_waw;
    assign sb_busy  = r_busy;

    always_comb begin
        w_busy_nxt = r_busy;
        if (lg_wb) begin
            w_busy_nxt[lg_wb_dest] = 1'b0;
        end
        if (lg_issue && !ds_stall) begin
            w_busy_nxt[lg_issue_dest] = 1'b1;
        end
        if (flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

`ifdef BYPASS_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (ds_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bypass_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bypass_hazard_unit
// Purpose  : Directed vector table plus scoreboard sequences for bypass_hazard_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bypass_hazard_unit;

    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 2;
    localparam int AW      = 5;
    localparam int SEL_W   = 2;
    localparam int NVEC    = 11;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     ds_valid;
    logic [NUM_SRC*AW-1:0]    ds_src_addr;
    logic [NUM_SRC-1:0]       ds_src_used;
    logic [NUM_FWD*AW-1:0]    st_dest;
    logic [NUM_FWD-1:0]       st_we;
    logic [NUM_FWD-1:0]       st_rdy;
    logic                     lg_issue;
    logic [AW-1:0]            lg_issue_dest;
    logic                     lg_wb;
    logic [AW-1:0]            lg_wb_dest;
    logic                     flush;
    logic [NUM_SRC*SEL_W-1:0] fw_sel;
    logic                     ds_stall;
    logic [31:0]              sb_busy;
`ifdef BYPASS_PERF_CNT_EN
    logic [31:0]              stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bypass_hazard_unit #(
        .NUM_SRC (NUM_SRC),
        .NUM_FWD (NUM_FWD),
        .AW      (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ds_valid      (ds_valid),
        .ds_src_addr   (ds_src_addr),
        .ds_src_used   (ds_src_used),
        .st_dest       (st_dest),
        .st_we         (st_we),
        .st_rdy        (st_rdy),
        .lg_issue      (lg_issue),
        .lg_issue_dest (lg_issue_dest),
        .lg_wb         (lg_wb),
        .lg_wb_dest    (lg_wb_dest),
        .flush         (flush),
        .fw_sel        (fw_sel),
        .ds_stall      (ds_stall),
        .sb_busy       (sb_busy)
`ifdef BYPASS_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [AW-1:0] s0;
        logic [AW-1:0] s1;
        logic [1:0]    used;
        logic [AW-1:0] d0;
        logic [AW-1:0] d1;
        logic [1:0]    we;
        logic [1:0]    rdy;
        logic          wb;
        logic [AW-1:0] wbd;
        logic [1:0]    e_sel0;
        logic [1:0]    e_sel1;
        logic          e_stall;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        ds_valid      = 1'b0;
        ds_src_addr   = '0;
        ds_src_used   = '0;
        st_dest       = '0;
        st_we         = '0;
        st_rdy        = '0;
        lg_issue      = 1'b0;
        lg_issue_dest = '0;
        lg_wb         = 1'b0;
        lg_wb_dest    = '0;
        flush         = 1'b0;
    endtask

    // Advance to just after the next rising edge so new inputs land mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // valid s0 s1 used d0 d1 we rdy wb wbd sel0 sel1 stall
        vecs[0]  = '{1, 5, 0, 2'b01, 5, 0, 2'b01, 2'b01, 0, 0, 2'd1, 2'd0, 0};
        vecs[1]  = '{1, 0, 7, 2'b10, 7, 7, 2'b11, 2'b11, 0, 0, 2'd0, 2'd1, 0};
        vecs[2]  = '{1, 9, 0, 2'b01, 9, 0, 2'b01, 2'b00, 0, 0, 2'd1, 2'd0, 1};
        vecs[3]  = '{1, 9, 0, 2'b01, 0, 9, 2'b10, 2'b10, 0, 0, 2'd2, 2'd0, 0};
        vecs[4]  = '{1, 0, 0, 2'b11, 0, 0, 2'b11, 2'b00, 0, 0, 2'd0, 2'd0, 0};
        vecs[5]  = '{0, 5, 6, 2'b11, 5, 6, 2'b11, 2'b00, 0, 0, 2'd0, 2'd0, 0};
        vecs[6]  = '{1, 5, 6, 2'b00, 5, 6, 2'b11, 2'b00, 0, 0, 2'd0, 2'd0, 0};
        vecs[7]  = '{1, 0, 4, 2'b10, 0, 0, 2'b00, 2'b00, 1, 4, 2'd0, 2'd3, 0};
        vecs[8]  = '{1, 4, 8, 2'b11, 0, 4, 2'b10, 2'b10, 1, 4, 2'd2, 2'd0, 0};
        vecs[9]  = '{1, 11, 0, 2'b01, 11, 0, 2'b00, 2'b01, 0, 0, 2'd0, 2'd0, 0};
        vecs[10] = '{1, 13, 14, 2'b11, 13, 13, 2'b11, 2'b01, 0, 0, 2'd1, 2'd0, 0};

        idle();
        reset = 1'b1;
        #12;
        check("reset_busy", sb_busy, 32'h0);
        check("reset_stall", {31'b0, ds_stall}, 32'h0);
`ifdef BYPASS_PERF_CNT_EN
        check("reset_cnt", stall_cnt, 32'h0);
`endif
        reset = 1'b0;
        step();

        for (int v = 0; v < NVEC; v++) begin
            ds_valid    = vecs[v].valid;
            ds_src_addr = {vecs[v].s1, vecs[v].s0};
            ds_src_used = vecs[v].used;
            st_dest     = {vecs[v].d1, vecs[v].d0};
            st_we       = vecs[v].we;
            st_rdy      = vecs[v].rdy;
            lg_wb       = vecs[v].wb;
            lg_wb_dest  = vecs[v].wbd;
            @(negedge clk);
            check($sformatf("vec%0d_sel0", v), {30'b0, fw_sel[1:0]}, {30'b0, vecs[v].e_sel0});
            check($sformatf("vec%0d_sel1", v), {30'b0, fw_sel[3:2]}, {30'b0, vecs[v].e_sel1});
            check($sformatf("vec%0d_stall", v), {31'b0, ds_stall}, {31'b0, vecs[v].e_stall});
            step();
        end
        idle();
        step();
        check("table_no_busy", sb_busy, 32'h0);

        // Load-use stall blocks a simultaneous long issue.
        ds_valid = 1'b1; ds_src_addr = 10'(9); ds_src_used = 2'b01;
        st_dest = 10'(9); st_we = 2'b01; st_rdy = 2'b00;
        lg_issue = 1'b1; lg_issue_dest = 5'd8;
        @(negedge clk);
        check("lu_stall", {31'b0, ds_stall}, 32'h1);
        step();
        idle();
        st_dest = 10'(9 << AW); st_we = 2'b10; st_rdy = 2'b10;
        ds_valid = 1'b1; ds_src_addr = 10'(9); ds_src_used = 2'b01;
        @(negedge clk);
        check("lu_blocked_issue", sb_busy, 32'h0);
        check("lu_resolved_sel", {30'b0, fw_sel[1:0]}, 32'd2);
        check("lu_resolved_stall", {31'b0, ds_stall}, 32'h0);
        step();

        // Scoreboard: issue r12, dependent stalls, write-back bypasses.
        idle();
        lg_issue = 1'b1; lg_issue_dest = 5'd12;
        @(negedge clk);
        check("sb_issue_nostall", {31'b0, ds_stall}, 32'h0);
        step();
        idle();
        @(negedge clk);
        check("sb_busy12", sb_busy, 32'h0000_1000);
        ds_valid = 1'b1; ds_src_addr = 10'(12); ds_src_used = 2'b01;
        #1;
        check("sb_dep_stall", {31'b0, ds_stall}, 32'h1);
        check("sb_dep_sel", {30'b0, fw_sel[1:0]}, 32'd0);
        step();
        lg_wb = 1'b1; lg_wb_dest = 5'd12;
        @(negedge clk);
        check("sb_wb_sel", {30'b0, fw_sel[1:0]}, 32'd3);
        check("sb_wb_stall", {31'b0, ds_stall}, 32'h0);
        step();
        idle();
        @(negedge clk);
        check("sb_cleared", sb_busy, 32'h0);

        // Set wins over a same-cycle clear of the same register.
        step();
        lg_issue = 1'b1; lg_issue_dest = 5'd3;
        step();
        lg_issue_dest = 5'd20;
        step();
        lg_issue = 1'b1; lg_issue_dest = 5'd3; lg_wb = 1'b1; lg_wb_dest = 5'd3; ds_valid = 1'b1;
        @(negedge clk);
        check("setclr_nostall", {31'b0, ds_stall}, 32'h0);
        step();
        idle();
        @(negedge clk);
        check("setclr_busy", sb_busy, 32'h0010_0008);

        // WAW: reissue to busy r3 without write-back stalls decode.
        ds_valid = 1'b1; lg_issue = 1'b1; lg_issue_dest = 5'd3;
        #1;
        check("waw_stall", {31'b0, ds_stall}, 32'h1);
        step();
        idle();

        // Flush clears everything, overriding a concurrent issue.
        flush = 1'b1; lg_issue = 1'b1; lg_issue_dest = 5'd6;
        step();
        idle();
        @(negedge clk);
        check("flush_busy", sb_busy, 32'h0);

        // Asynchronous reset mid-operation.
        step();
        lg_issue = 1'b1; lg_issue_dest = 5'd10;
        step();
        lg_issue_dest = 5'd11;
        step();
        idle();
        check("pre_reset_busy", sb_busy, 32'h0000_0C00);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_busy", sb_busy, 32'h0);
`ifdef BYPASS_PERF_CNT_EN
        check("async_reset_cnt", stall_cnt, 32'h0);
`endif
        step();
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
